ld3320_bus_responder: RTL

Synthesizable responder for the LD3320 8-bit parallel register bus (P, A0, CSB, WRB, RDB), the target side of the transactions our init and recognition sequencers issue. It decodes address and data phases from the asynchronous bus strobes and holds a 256×8 register file. It returns register contents on read cycles and exposes the file to local logic. It serves as an on-chip loopback target for bring-up and as the DUT-side model in sequencer benches.

---
 rtl/ld3320_pkg.sv | 30 +++
 rtl/ld3320_bus_responder_if.sv | 14 +
 rtl/ld3320_strobe_sync.sv | 40 ++++
 rtl/ld3320_bus_responder.sv | 129 ++++++++++++
 4 files changed

// File: rtl/ld3320_pkg.sv
// ld3320_pkg: shared definitions for the LD3320 parallel-bus responder.
//   - register address constants used by the init/recognition sequencers
//   - FSM state enum
//   - bit positions of the control lines inside the synchronizer vector
package ld3320_pkg;

  localparam logic [7:0] REG_FIFO_DATA = 8'h05;
  localparam logic [7:0] REG_STATUS    = 8'h06;  // read-only from the bus
  localparam logic [7:0] REG_FIFO_CTRL = 8'h17;
  localparam logic [7:0] REG_INT_EN    = 8'h29;
  localparam logic [7:0] REG_INT_REQ   = 8'h2B;
  localparam logic [7:0] REG_CMD       = 8'h37;
  localparam logic [7:0] REG_BUSY      = 8'hB2;

  typedef enum logic [1:0] {IDLE, ADDR, RD_DRIVE} state_e;

  // control-line positions in the synchronized vector
  localparam int SB_A0  = 0;
  localparam int SB_CSB = 1;
  localparam int SB_WRB = 2;
  localparam int SB_RDB = 3;
  localparam int SB_W   = 4;

  // true for registers the sequencers actually touch
  function automatic logic is_seq_reg(input logic [7:0] a);
    return a inside {REG_FIFO_DATA, REG_STATUS, REG_FIFO_CTRL, REG_INT_EN,
                     REG_INT_REQ, REG_CMD, REG_BUSY};
  endfunction

endpackage

// File: rtl/ld3320_bus_responder_if.sv
// ld3320_bus_responder_if: LD3320 control strobes (A0, CSB, WRB, RDB).
//   master: initiator (sequencer / bench) drives the strobes
//   slave : responder samples them
// The data bus P is a plain inout on the responder so the tristate
// resolves directly at the pin.
interface ld3320_bus_responder_if;
  logic A0;
  logic CSB;
  logic WRB;
  logic RDB;

  modport master (output A0, CSB, WRB, RDB);
  modport slave  (input  A0, CSB, WRB, RDB);
endinterface

// File: rtl/ld3320_strobe_sync.sv
// ld3320_strobe_sync: multi-bit synchronizer with registered edge outputs.
//   clk, sys_rstn : clock, async active-low reset
//   d             : asynchronous inputs
//   lvl           : synchronized level (last of STAGES flops)
//   rise / fall   : registered edge flags, aligned with the cycle in which
//                   lvl first shows the new value
// STAGES must be at least 2.
module ld3320_strobe_sync #(
  parameter int             W       = 4,
  parameter int             STAGES  = 2,
  parameter logic [W-1:0]   RST_VAL = '1
) (
  input  logic         clk,
  input  logic         sys_rstn,
  input  logic [W-1:0] d,
  output logic [W-1:0] lvl,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  // index 0 is the newest sample
  logic [STAGES-1:0][W-1:0] sync_q;

  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      sync_q <= {STAGES{RST_VAL}};
      rise   <= '0;
      fall   <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      // compare the value about to enter the last stage with the one leaving
      // it, so the edge flag lines up with lvl without an extra cycle
      rise   <= sync_q[STAGES-2] & ~sync_q[STAGES-1];
      fall   <= ~sync_q[STAGES-2] & sync_q[STAGES-1];
    end
  end

  assign lvl = sync_q[STAGES-1];

endmodule

// File: rtl/ld3320_bus_responder.sv
// ld3320_bus_responder: target side of the LD3320 8-bit parallel bus with a
// 256x8 register file.
//   clk, sys_rstn : clock, async active-low reset
//   P             : bus data, driven only while a read data phase is accepted
//   bus           : A0/CSB/WRB/RDB strobes (slave modport)
//   loc_addr      : local read address
//   loc_rdata     : reg[loc_addr], combinational
//   proto_err     : one-cycle pulse on a protocol violation
//   wr_valid/wr_addr/wr_data : write log, present with LD3320_RSP_WRLOG_EN
// Optional feature macro: LD3320_RSP_WRLOG_EN.
module ld3320_bus_responder
  import ld3320_pkg::*;
#(
  parameter logic [7:0] RESET_06    = 8'h87,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    sys_rstn,
  inout  wire  [7:0]              P,
  ld3320_bus_responder_if.slave   bus,
  input  logic [7:0]              loc_addr,
  output logic [7:0]              loc_rdata,
  output logic                    proto_err
`ifdef LD3320_RSP_WRLOG_EN
  ,
  output logic                    wr_valid,
  output logic [7:0]              wr_addr,
  output logic [7:0]              wr_data
`endif
);

  logic [SB_W-1:0] lvl, rise, fall;

  // strobes idle high; A0 idle value is irrelevant since its edges are unused
  ld3320_strobe_sync #(
    .W       (SB_W),
    .STAGES  (SYNC_STAGES),
    .RST_VAL ({SB_W{1'b1}})
  ) u_sync (
    .clk      (clk),
    .sys_rstn (sys_rstn),
    .d        ({bus.RDB, bus.WRB, bus.CSB, bus.A0}),
    .lvl      (lvl),
    .rise     (rise),
    .fall     (fall)
  );

  logic unused_edges;
  assign unused_edges = ^{rise[SB_A0], fall[SB_A0], fall[SB_CSB]};

  state_e     state;
  logic [7:0] addr_q, rd_q;
  logic       oe_q;
  logic [7:0] regs [256];

  logic cs, a0, both_lo_new, viol, addr_ph, wr_ph, rd_ph, rd_end;

  always_comb begin
    cs = ~lvl[SB_CSB];
    a0 = lvl[SB_A0];
    // both low now and at least one just fell => first sample of the overlap
    both_lo_new = ~lvl[SB_WRB] & ~lvl[SB_RDB] & (fall[SB_WRB] | fall[SB_RDB]);
    viol = both_lo_new
         | ((state == RD_DRIVE) & (rise[SB_WRB] | fall[SB_WRB]))
         | ((state == IDLE) & cs & ~a0 & (rise[SB_WRB] | fall[SB_RDB]));
    addr_ph = ~viol & rise[SB_WRB] & cs & a0 & (state != RD_DRIVE);
    wr_ph   = ~viol & rise[SB_WRB] & cs & ~a0 & (state == ADDR);
    rd_ph   = ~viol & fall[SB_RDB] & cs & ~a0 & (state == ADDR);
    rd_end  = ~viol & (state == RD_DRIVE) & (rise[SB_RDB] | rise[SB_CSB]);
  end

  // P is only stable for the hold window around the strobe, which covers
  // the commit cycle, so it is sampled straight from the pin here.
  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      for (int i = 0; i < 256; i++)
        regs[i] <= (i == int'(REG_STATUS)) ? RESET_06 : 8'h00;
    end else if (wr_ph && addr_q != REG_STATUS) begin
      regs[addr_q] <= P;
    end
  end

  assign loc_rdata = regs[loc_addr];

  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state     <= IDLE;
      addr_q    <= 8'h00;
      rd_q      <= 8'h00;
      oe_q      <= 1'b0;
      proto_err <= 1'b0;
`ifdef LD3320_RSP_WRLOG_EN
      wr_valid  <= 1'b0;
      wr_addr   <= 8'h00;
      wr_data   <= 8'h00;
`endif
    end else begin
      proto_err <= viol;
`ifdef LD3320_RSP_WRLOG_EN
      // logs dropped status writes too
      wr_valid  <= wr_ph;
      if (wr_ph) begin
        wr_addr <= addr_q;
        wr_data <= P;
      end
`endif
      if (viol) begin
        state <= IDLE;
        oe_q  <= 1'b0;
      end else if (addr_ph) begin
        addr_q <= P;
        state  <= ADDR;
      end else if (wr_ph) begin
        state <= IDLE;
      end else if (rd_ph) begin
        rd_q  <= regs[addr_q];
        oe_q  <= 1'b1;
        state <= RD_DRIVE;
      end else if (rd_end) begin
        oe_q  <= 1'b0;
        state <= IDLE;
      end
      // CSB rising in ADDR keeps addr_q and the state
    end
  end

  assign P = oe_q ? rd_q : 8'hzz;

endmodule
